// File: rtl/cross_pkg.sv
// Shared definitions for the cross_event tx/rx pair: handshake FSM encoding and default widths.
package cross_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 2;
  localparam int unsigned TIMEOUT_DEF    = 1023;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACKW = 2'd2
  } crossState_e;

endpackage

// File: rtl/cross_signal.sv
// Two-flop level synchronizer into the clkB domain; clkA is kept for interface symmetry only.
module cross_signal (
  input  logic clkA,
  input  logic clkB,
  input  logic sigA,
  output logic sigB
);

  logic [1:0] syncQ;
  wire unusedClkA = clkA;

  // No reset: during reset the flops keep tracking the far side so a stale level is visible at release.
  always_ff @(posedge clkB) begin
    syncQ <= {syncQ[0], sigA};
  end

  assign sigB = syncQ[1];

endmodule

// File: rtl/cross_event_tx.sv
// Source side of a four-phase req/ack crossing: events are queued in a small FIFO and sent one per handshake.
// Optional per-phase watchdog enabled by defining CROSS_EVENT_TX_TIMEOUT_EN.
module cross_event_tx
  import cross_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned C_ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned C_TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    event_valid,
  input  logic [C_DATA_WIDTH-1:0] event_data,
  output logic                    event_ready,
  output logic                    req_out,
  output logic [C_DATA_WIDTH-1:0] data_out,
  input  logic                    ack_in,
  output logic                    ovf,
  input  logic                    ovf_clr,
  output logic                    timeout_err,
  output logic [C_ADDR_WIDTH:0]   level
);

  localparam int unsigned DEPTH = 1 << C_ADDR_WIDTH;
  localparam int unsigned LVL_W = C_ADDR_WIDTH + 1;

  logic                    ackS;
  logic [C_DATA_WIDTH-1:0] mem [DEPTH];
  logic [C_ADDR_WIDTH-1:0] wrPtr;
  logic [C_ADDR_WIDTH-1:0] rdPtr;
  crossState_e             state;
  crossState_e             stateNext;
  logic                    push;
  logic                    pop;
  logic                    toHit;
  logic                    toSet;

  cross_signal uAckSync (
    .clkA (clk),
    .clkB (clk),
    .sigA (ack_in),
    .sigB (ackS)
  );

  // A full FIFO refuses the offer even if the head leaves on the same edge.
  assign event_ready = (level != LVL_W'(DEPTH));
  assign push        = event_valid && event_ready;

`ifdef CROSS_EVENT_TX_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(C_TIMEOUT + 1);

  logic [TO_W-1:0] phaseCnt;

  // Fires on the edge at which the phase has lasted C_TIMEOUT cycles.
  assign toHit = (state != IDLE) && (phaseCnt == TO_W'(C_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phaseCnt <= '0;
    end else if ((stateNext != state) || (state == IDLE)) begin
      phaseCnt <= '0;
    end else begin
      phaseCnt <= phaseCnt + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
    end else if (toSet) begin
      timeout_err <= 1'b1;
    end else if (ovf_clr) begin
      timeout_err <= 1'b0;
    end
  end
`else
  localparam int unsigned unusedTimeout = C_TIMEOUT;
  wire unusedToSet = toSet;

  assign toHit       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Handshake next-state and pop decision.
  always_comb begin
    stateNext = state;
    pop       = 1'b0;
    toSet     = 1'b0;
    case (state)
      IDLE: begin
        if (level != '0) stateNext = REQ;
      end
      REQ: begin
        if (ackS) begin
          pop       = 1'b1;
          stateNext = ACKW;
        end else if (toHit) begin
          pop       = 1'b1;
          toSet     = 1'b1;
          stateNext = ACKW;
        end
      end
      ACKW: begin
        if (!ackS) begin
          stateNext = IDLE;
        end else if (toHit) begin
          toSet     = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = ACKW;
    endcase
  end

  // Starting in ACKW keeps a stale high ack from completing a phantom transfer after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ACKW;
      req_out  <= 1'b0;
      data_out <= '0;
      level    <= '0;
      wrPtr    <= '0;
      rdPtr    <= '0;
      ovf      <= 1'b0;
    end else begin
      state   <= stateNext;
      req_out <= (stateNext == REQ);
      if ((state == IDLE) && (stateNext == REQ)) data_out <= mem[rdPtr];
      if (push) wrPtr <= wrPtr + C_ADDR_WIDTH'(1);
      if (pop)  rdPtr <= rdPtr + C_ADDR_WIDTH'(1);
      level <= level + LVL_W'(push) - LVL_W'(pop);
      if (event_valid && !event_ready) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= event_data;
  end

endmodule
